// File: rtl/rx_serial_pkg.sv
// Shared constants for the 7E1 serial receiver: FSM state codes, baud divisors and frame length.
package rx_serial_pkg;

  // The numeric codes are visible on db_estado, so they are pinned explicitly.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_ESPERA  = 4'd2,
    ST_AMOSTRA = 4'd3,
    ST_FINAL   = 4'd4,
    ST_BREAK   = 4'd5
  } state_e;

  localparam int BAUD_DIV_115200 = 434;
  localparam int BAUD_DIV_9600   = 5208;
  localparam int FRAME_BITS      = 9;

endpackage

// File: rtl/rx_serial_7e1_if.sv
// Pin/handshake bundle between the serial line, the 7E1 receiver and the character consumer.
interface rx_serial_7e1_if;
  logic       rx;
  logic       recebe_dado;
  logic [6:0] dados_ascii;
  logic       tem_dado;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_stop;
  logic       db_rx;
  logic       db_tick;
  logic [3:0] db_estado;

  // The receiver.
  modport slave (
    input  rx, recebe_dado,
    output dados_ascii, tem_dado, pronto, erro_paridade, erro_stop,
           db_rx, db_tick, db_estado
  );

  // The line driver / character consumer.
  modport master (
    output rx, recebe_dado,
    input  dados_ascii, tem_dado, pronto, erro_paridade, erro_stop,
           db_rx, db_tick, db_estado
  );
endinterface

// File: rtl/rx_serial_uc.sv
// Control FSM of the 7E1 receiver: finds the start bit, paces the nine samples, closes the frame.
module rx_serial_uc
  import rx_serial_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       tick,
  input  logic       half,
  input  logic       fim_bits,
  output logic       zera,
  output logic       amostra,
  output logic       carrega,
  output logic       pronto,
  output logic [3:0] db_estado
);

  state_e state_q, state_d;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    zera    = 1'b0;
    amostra = 1'b0;
    carrega = 1'b0;
    pronto  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        zera = 1'b1;
        if (!rx) state_d = ST_START;
      end
      ST_START: begin
        if (half) begin
          if (!rx) begin
            state_d = ST_ESPERA;
            zera    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ESPERA: if (tick) state_d = ST_AMOSTRA;
      ST_AMOSTRA: begin
        amostra = 1'b1;
        state_d = fim_bits ? ST_FINAL : ST_ESPERA;
      end
      ST_FINAL: begin
        carrega = 1'b1;
        pronto  = 1'b1;
        // The stop bit sampled one cycle ago is still on the line; low means a break.
        state_d = rx ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: if (rx) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: rtl/rx_serial_7e1.sv
// Asynchronous 7E1 serial receiver: baud/bit counters, shift register and held outputs.
// Optional RX_SYNC_EN adds a 2-flop input synchronizer (2 cycles extra latency).
module rx_serial_7e1
  import rx_serial_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_115200,
  parameter int DIV_W    = 9
) (
  input  logic             clock,
  input  logic             reset,
  rx_serial_7e1_if.slave   bus
);

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], bus.rx};
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = bus.rx;
`endif

  logic zera, amostra, carrega, pronto, tick, half, fim_bits;
  logic [3:0] estado;

  rx_serial_uc u_uc (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx_s),
    .tick      (tick),
    .half      (half),
    .fim_bits  (fim_bits),
    .zera      (zera),
    .amostra   (amostra),
    .carrega   (carrega),
    .pronto    (pronto),
    .db_estado (estado)
  );

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       sh_q, sh_d;
  logic [6:0]       dados_q, dados_d;
  logic             perr_q, perr_d;
  logic             serr_q, serr_d;
  logic             tem_q, tem_d;

  assign tick     = (cnt_q == DIV_W'(BAUD_DIV - 1));
  assign half     = (cnt_q == DIV_W'(BAUD_DIV / 2 - 1));
  assign fim_bits = (bit_cnt_q == 4'(FRAME_BITS - 1));

  always_comb begin
    cnt_d     = (zera || tick) ? '0 : cnt_q + DIV_W'(1);
    bit_cnt_d = zera ? 4'd0 : (amostra ? bit_cnt_q + 4'd1 : bit_cnt_q);
    // Bits arrive LSB first and enter at the top, so after nine samples sh = {stop, p, d6..d0}.
    sh_d      = amostra ? {rx_s, sh_q[8:1]} : sh_q;
    dados_d   = carrega ? sh_q[6:0]  : dados_q;
    perr_d    = carrega ? ^sh_q[7:0] : perr_q;
    serr_d    = carrega ? ~sh_q[8]   : serr_q;
    // A completing frame outranks a same-cycle acknowledge.
    tem_d     = carrega ? 1'b1 : (bus.recebe_dado ? 1'b0 : tem_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_cnt_q <= 4'd0;
      sh_q      <= 9'd0;
      dados_q   <= 7'd0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      tem_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      dados_q   <= dados_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      tem_q     <= tem_d;
    end
  end

  assign bus.dados_ascii   = dados_q;
  assign bus.tem_dado      = tem_q;
  assign bus.pronto        = pronto;
  assign bus.erro_paridade = perr_q;
  assign bus.erro_stop     = serr_q;
  assign bus.db_rx         = rx_s;
  assign bus.db_tick       = tick;
  assign bus.db_estado     = estado;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Scoreboard bench for rx_serial_7e1 with BAUD_DIV=16: directed 7E1 cases plus random frames.
module tb_rx_serial_7e1;

  localparam int B = 16;
  localparam int H = B / 2;
`ifdef RX_SYNC_EN
  localparam int LAT = H + 9 * B + 2 + 2;
`else
  localparam int LAT = H + 9 * B + 2;
`endif

  typedef struct {
    logic [6:0] data;
    logic       perr;
    logic       serr;
    int         start_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];
  exp_t cur;
  logic       pending         = 1'b0;
  logic       ack_now         = 1'b0;
  logic       ack_phase       = 1'b0;
  logic       ack_on_final    = 1'b0;
  logic       ack_final_phase = 1'b0;
  logic [6:0] last_data       = 7'd0;
  logic       last_serr       = 1'b0;

  rx_serial_7e1_if bus ();

  rx_serial_7e1 #(.BAUD_DIV(B), .DIV_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: even parity over the 7 data bits plus the parity bit; stop must be 1.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = ($countones({p, d}) % 2) != 0;
    e.serr = (stop == 1'b0);
    @(negedge clock);
    bus.rx = 1'b0;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    last_data = d;
    last_serr = e.serr;
    repeat (B) @(negedge clock);
    for (int k = 0; k < 7; k++) begin
      bus.rx = d[k];
      repeat (B) @(negedge clock);
    end
    bus.rx = p;
    repeat (B) @(negedge clock);
    bus.rx = stop;
    repeat (B) @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 32'(n >= 400), 32'd0);
    repeat (4) @(negedge clock);
  endtask

  // Monitor: pops one expectation per pronto pulse and checks the held outputs one cycle later.
  initial begin
    forever begin
      @(negedge clock);
      if (pending) begin
        pending = 1'b0;
        check("dados_ascii",   32'(bus.dados_ascii),   32'(cur.data));
        check("erro_paridade", 32'(bus.erro_paridade), 32'(cur.perr));
        check("erro_stop",     32'(bus.erro_stop),     32'(cur.serr));
        check("tem_dado_set",  32'(bus.tem_dado),      32'd1);
        check("pronto_width",  32'(bus.pronto),        32'd0);
        if (ack_final_phase) begin
          bus.recebe_dado = 1'b0;
          ack_final_phase = 1'b0;
        end
      end
      if (ack_phase) begin
        check("tem_dado_ack", 32'(bus.tem_dado), 32'd0);
        bus.recebe_dado = 1'b0;
        ack_phase = 1'b0;
      end else if (ack_now) begin
        bus.recebe_dado = 1'b1;
        ack_now   = 1'b0;
        ack_phase = 1'b1;
      end
      if (bus.pronto === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pronto", 32'd1, 32'd0);
        end else begin
          int lat;
          cur = exp_q.pop_front();
          lat = cyc - cur.start_cyc;
          check("latency_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
          if (lat < LAT - 1 || lat > LAT + 1)
            $display("  latency actual=%0d required=%0d", lat, LAT);
          pending = 1'b1;
          if (ack_on_final) begin
            bus.recebe_dado = 1'b1;
            ack_on_final    = 1'b0;
            ack_final_phase = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx = 1'b1;
    bus.recebe_dado = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_dados",  32'(bus.dados_ascii),   32'd0);
    check("rst_tem",    32'(bus.tem_dado),      32'd0);
    check("rst_pronto", 32'(bus.pronto),        32'd0);
    check("rst_perr",   32'(bus.erro_paridade), 32'd0);
    check("rst_serr",   32'(bus.erro_stop),     32'd0);
    check("rst_estado", 32'(bus.db_estado),     32'd0);
    check("rst_tick",   32'(bus.db_tick),       32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Clean frame, then acknowledge it.
    send_frame(7'h41, 1'b0, 1'b1);
    drain();
    ack_now = 1'b1;
    repeat (6) @(negedge clock);

    // Wrong parity.
    send_frame(7'h43, 1'b0, 1'b1);
    drain();

    // Stop bit low, line held low as a break.
    send_frame(7'h41, 1'b0, 1'b0);
    repeat (3 * B) @(negedge clock);
    check("break_state", 32'(bus.db_estado), 32'd5);
    bus.rx = 1'b1;
    repeat (6) @(negedge clock);
    check("break_exit", 32'(bus.db_estado), 32'd0);
    drain();

    // Short glitch: no frame, outputs untouched.
    bus.rx = 1'b0;
    repeat (4) @(negedge clock);
    bus.rx = 1'b1;
    repeat (2 * B) @(negedge clock);
    check("glitch_dados",  32'(bus.dados_ascii), 32'(last_data));
    check("glitch_serr",   32'(bus.erro_stop),   32'(last_serr));
    check("glitch_estado", 32'(bus.db_estado),   32'd0);

    // Reset in the middle of a frame (after the 3rd data bit).
    @(negedge clock);
    bus.rx = 1'b0;
    repeat (B) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      bus.rx = k[0];
      repeat (B) @(negedge clock);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_rst_dados",  32'(bus.dados_ascii),   32'd0);
    check("mid_rst_tem",    32'(bus.tem_dado),      32'd0);
    check("mid_rst_perr",   32'(bus.erro_paridade), 32'd0);
    check("mid_rst_serr",   32'(bus.erro_stop),     32'd0);
    check("mid_rst_pronto", 32'(bus.pronto),        32'd0);
    check("mid_rst_estado", 32'(bus.db_estado),     32'd0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    send_frame(7'h55, 1'b0, 1'b1);
    drain();

    // Acknowledge coinciding with frame end: new frame keeps tem_dado high.
    ack_on_final = 1'b1;
    send_frame(7'h12, 1'b0, 1'b1);
    drain();
    check("ack_on_final_hold", 32'(bus.tem_dado), 32'd1);

    // Randomized frames, back to back, with occasional parity and stop errors.
    for (int i = 0; i < 25; i++) begin
      logic [6:0] d;
      logic p, stop;
      d    = 7'($urandom_range(0, 127));
      p    = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, p, stop);
      if (!stop) begin
        repeat (B) @(negedge clock);
        bus.rx = 1'b1;
      end
      repeat ($urandom_range(4, 2 * B)) @(negedge clock);
    end
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
